// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised as start/8 data (LSB first)/optional parity/stop bits.
// Latency: a byte pushed into an empty FIFO while idle drives the start bit from the next clock edge.
// Backpressure: tx_ready drops while the FIFO holds FIFO_DEPTH bytes; tx_valid is ignored while it is low.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset; forces tx high and flushes the FIFO
//   tx_data    byte to queue, sampled when tx_valid && tx_ready
//   tx_valid   tx_data is valid
//   tx_ready   FIFO has room (combinational from fifo_count)
//   tx         registered serial line, idle high
//   tx_busy    registered, high while a frame is on the line
//   fifo_count bytes currently queued
module uart_tx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W      = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int CW         = AW + 1;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_COUNT - 1);
   localparam logic [CW-1:0]    FIFO_FULL = CW'(FIFO_DEPTH);
   // Index of the final stop bit: 0 for one stop bit, 1 for two.
   localparam logic             STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   // FIFO storage and pointers; depth is a power of two so pointers wrap naturally.
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // Frame datapath
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic             stop_idx;
   logic [7:0]       shreg;
   logic [7:0]       shreg_nxt;
   logic             par;
   logic             par_nxt;
   logic             bit_done;
   logic             tx_nxt;
   logic             busy_nxt;

   // Full blocks the push even if a pop happens on the same edge.
   assign tx_ready = (fifo_count != FIFO_FULL);
   assign push     = tx_valid & tx_ready;
   assign bit_done = (baud_cnt == BAUD_LAST);

   // ------------------------------------------------------------------
   // Transmit FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register (tx and tx_busy register on the same edge)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state   <= state_nxt;
         tx      <= tx_nxt;
         tx_busy <= busy_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state; the pop is tied to every entry into START
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_count != '0) begin
               state_nxt = START;
               pop       = 1'b1;
            end
         end
         START: begin
            if (bit_done) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (bit_done && (bit_idx == 3'd7)) begin
               state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (bit_done && (stop_idx == STOP_LAST)) begin
               // Chain straight into the next frame when data is waiting.
               if (fifo_count != '0) begin
                  state_nxt = START;
                  pop       = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs. The line level is derived from the state being entered,
   // so it only moves when the state or the shift register moves, i.e. on
   // bit boundaries.
   // ------------------------------------------------------------------
   always_comb begin
      shreg_nxt = shreg;
      par_nxt   = par;
      tx_nxt    = 1'b1;
      busy_nxt  = (state_nxt != IDLE);
      if (pop) begin
         shreg_nxt = mem[rd_ptr];
         par_nxt   = (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
      end else if ((state == DATA) && bit_done) begin
         shreg_nxt = {1'b0, shreg[7:1]};
      end
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
         PARITY:  tx_nxt = par_nxt;
         default: tx_nxt = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Baud counter, data bit index, stop bit index, shift register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par      <= 1'b0;
      end else begin
         shreg <= shreg_nxt;
         par   <= par_nxt;

         // Restart the bit timer on every bit boundary and hold it in IDLE.
         if ((state == IDLE) || bit_done) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end

         if (state == DATA) begin
            if (bit_done) begin
               bit_idx <= bit_idx + 3'd1;
            end
         end else begin
            bit_idx <= '0;
         end

         if (state == STOP) begin
            if (bit_done) begin
               stop_idx <= ~stop_idx;
            end
         end else begin
            stop_idx <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (default, even parity, odd parity, two stop bits) at BAUD_COUNT=10.
// Stimulus pushes expected frames into a scoreboard; a per-instance monitor decodes the line and compares.
module tb_uart_tx;

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic       par;
      bit         b2b;   // frame must start with no idle cycle after the previous one
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data [4];
   logic [3:0] tx_valid;
   logic [3:0] tx_ready;
   logic [3:0] tx_line;
   logic [3:0] tx_busy;
   logic [2:0] fifo_count [4];

   exp_t sb_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic sb_push(input int inst, input logic [7:0] d, input logic p, input bit b2b);
      exp_t e;
      e.inst = inst;
      e.data = d;
      e.par  = p;
      e.b2b  = b2b;
      sb_q.push_back(e);
   endtask

   // Count busy samples from the current negedge until busy falls (bounded).
   task automatic busy_len(input int i, output int n);
      int guard;
      n = 0;
      guard = 0;
      while ((n == 0 || tx_busy[i]) && guard < 1500) begin
         if (tx_busy[i]) n++;
         @(negedge clk);
         guard++;
      end
   endtask

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int PE   = (gi == 1 || gi == 2) ? 1 : 0;
      localparam int PO   = (gi == 2) ? 1 : 0;
      localparam int SB   = (gi == 3) ? 2 : 1;
      localparam int FLEN = 9 + PE + SB;

      uart_tx #(
         .CLK_FREQ   (1000),
         .BAUD_RATE  (100),
         .PARITY_EN  (PE),
         .PARITY_ODD (PO),
         .STOP_BITS  (SB),
         .FIFO_DEPTH (4)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .tx_data    (tx_data[gi]),
         .tx_valid   (tx_valid[gi]),
         .tx_ready   (tx_ready[gi]),
         .tx         (tx_line[gi]),
         .tx_busy    (tx_busy[gi]),
         .fifo_count (fifo_count[gi])
      );

      initial begin : mon
         exp_t        e;
         logic [11:0] bits;
         int          idle_cnt;
         int          idx;
         int          c;
         int          bad_c;
         logic        bad_tx;
         logic        bad_busy;
         bit          bad;
         bit          abort;
         idle_cnt = 0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               idle_cnt = 0;
            end else if (tx_line[gi] == 1'b1) begin
               idle_cnt++;
            end else begin
               idx = -1;
               for (int j = 0; j < sb_q.size(); j++) begin
                  if (idx < 0 && sb_q[j].inst == gi) idx = j;
               end
               if (idx < 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL frame_unexpected inst%0d: start bit seen, required none", gi);
                  c = 1;
                  while (c < FLEN * 10 && rst_n) begin
                     @(negedge clk);
                     c++;
                  end
               end else begin
                  e = sb_q[idx];
                  sb_q.delete(idx);
                  bits      = '1;
                  bits[0]   = 1'b0;
                  bits[8:1] = e.data;
                  if (PE != 0) bits[9] = e.par;
                  bad      = (e.b2b && idle_cnt != 0);
                  bad_c    = -1;
                  bad_tx   = 1'b1;
                  bad_busy = 1'b1;
                  abort    = 1'b0;
                  c        = 0;
                  while (c < FLEN * 10 && !abort) begin
                     if (c > 0) @(negedge clk);
                     if (!rst_n) begin
                        abort = 1'b1;
                     end else if (tx_line[gi] !== bits[c / 10] || tx_busy[gi] !== 1'b1) begin
                        if (bad_c < 0) begin
                           bad_c    = c;
                           bad_tx   = tx_line[gi];
                           bad_busy = tx_busy[gi];
                        end
                        bad = 1'b1;
                     end
                     c++;
                  end
                  if (!abort) begin
                     n_cmp++;
                     if (bad) begin
                        n_bad++;
                        $display("FAIL frame inst%0d byte %02h: cycle %0d tx=%b busy=%b gap=%0d, required tx=%b busy=1 gap=%0d",
                                 gi, e.data, bad_c, bad_tx, bad_busy, idle_cnt,
                                 (bad_c >= 0) ? bits[bad_c / 10] : 1'b0, e.b2b ? 0 : idle_cnt);
                     end
                  end
               end
               idle_cnt = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] burst [6];
      int         n;
      int         k;
      burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
      burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
      tx_valid = '0;
      for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;

      // Reset state of every instance
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("reset_tx",    int'(tx_line[i]), 1);
         chk("reset_busy",  int'(tx_busy[i]), 0);
         chk("reset_count", int'(fifo_count[i]), 0);
         chk("reset_ready", int'(tx_ready[i]), 1);
      end
      rst_n = 1'b1;

      // 0x55, default framing: push latency and count 0->1->0
      @(negedge clk);
      chk("lat_count_pre", int'(fifo_count[0]), 0);
      tx_data[0] = 8'h55; tx_valid[0] = 1'b1;
      sb_push(0, 8'h55, 1'b0, 1'b0);
      @(negedge clk);
      tx_valid[0] = 1'b0;
      chk("lat_count_n",  int'(fifo_count[0]), 1);
      chk("lat_tx_n",     int'(tx_line[0]), 1);
      chk("lat_busy_n",   int'(tx_busy[0]), 0);
      @(negedge clk);
      chk("lat_tx_n1",    int'(tx_line[0]), 0);
      chk("lat_count_n1", int'(fifo_count[0]), 0);
      busy_len(0, n);
      chk("frame55_busy_len", n, 100);
      chk("frame55_tx_idle",  int'(tx_line[0]), 1);

      // 0xA5 with even parity (parity bit 0), then odd parity (parity bit 1)
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         tx_data[i] = 8'hA5; tx_valid[i] = 1'b1;
         sb_push(i, 8'hA5, (i == 2), 1'b0);
         @(negedge clk);
         tx_valid[i] = 1'b0;
         @(negedge clk);
         busy_len(i, n);
         chk("parity_frame_len", n, 110);
      end

      // Two stop bits, 0x00 then 0xFF on consecutive cycles, back to back
      @(negedge clk);
      tx_data[3] = 8'h00; tx_valid[3] = 1'b1;
      sb_push(3, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      tx_data[3] = 8'hFF;
      sb_push(3, 8'hFF, 1'b0, 1'b1);
      @(negedge clk);
      tx_valid[3] = 1'b0;
      busy_len(3, n);
      chk("stop2_busy_len", n, 220);

      // Six bytes on six consecutive cycles into a depth-4 FIFO
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 5) begin
            chk("burst_ready_full", int'(tx_ready[0]), 0);
            chk("burst_count_full", int'(fifo_count[0]), 4);
         end else begin
            chk("burst_ready", int'(tx_ready[0]), 1);
            sb_push(0, burst[i], 1'b0, (i > 0));
         end
         tx_data[0] = burst[i]; tx_valid[0] = 1'b1;
      end
      k = 0;
      while (!tx_ready[0] && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("burst_wait_cycles", k, 97);
      chk("burst_count_pop",   int'(fifo_count[0]), 3);
      sb_push(0, burst[5], 1'b0, 1'b1);
      @(negedge clk);
      tx_valid[0] = 1'b0;
      chk("burst_count_6th", int'(fifo_count[0]), 4);
      busy_len(0, n);
      chk("burst_busy_len",  n, 499);
      chk("burst_count_end", int'(fifo_count[0]), 0);

      // Reset during data bit 3 with two bytes still queued
      @(negedge clk);
      tx_data[0] = 8'hC3; tx_valid[0] = 1'b1;
      sb_push(0, 8'hC3, 1'b0, 1'b0);
      @(negedge clk);
      tx_data[0] = 8'h3C;
      @(negedge clk);
      tx_data[0] = 8'h5A;
      @(negedge clk);
      tx_valid[0] = 1'b0;
      repeat (44) @(negedge clk);
      chk("rst_pre_busy",  int'(tx_busy[0]), 1);
      chk("rst_pre_count", int'(fifo_count[0]), 2);
      chk("rst_pre_bit3",  int'(tx_line[0]), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_tx",    int'(tx_line[0]), 1);
      chk("rst_async_busy",  int'(tx_busy[0]), 0);
      chk("rst_async_count", int'(fifo_count[0]), 0);
      chk("rst_async_ready", int'(tx_ready[0]), 1);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (tx_line[0] !== 1'b1 || tx_busy[0] !== 1'b0) k++;
      end
      chk("rst_no_frames", k, 0);

      // First byte after reset keeps the one-edge latency
      @(negedge clk);
      tx_data[0] = 8'h81; tx_valid[0] = 1'b1;
      sb_push(0, 8'h81, 1'b0, 1'b0);
      @(negedge clk);
      tx_valid[0] = 1'b0;
      chk("post_rst_tx_n",    int'(tx_line[0]), 1);
      chk("post_rst_count_n", int'(fifo_count[0]), 1);
      @(negedge clk);
      chk("post_rst_tx_n1",   int'(tx_line[0]), 0);
      busy_len(0, n);
      chk("post_rst_busy_len", n, 100);

      repeat (5) @(negedge clk);
      chk("sb_leftover", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
